lct_quality_pipe: RTL and testbench
===================================

LCT_QUALITY_PIPE -- requirements
Module: lct_quality_pipe

Interface
Parameters:
REQ-001 NCH, 2, number of LCT channels encoded per clock (1..4).
REQ-002 PIPE_DEPTH, 1, encode-to-output latency in clocks (1..4).
REQ-003 CNT_W, 16, width of each per-quality occupancy counter (8..32).

Ports (name, direction, width, meaning):
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 global_reset  in  1  asynchronous, active-high reset.
REQ-006 run3_en  in  1  1 selects Run-3 GEM-CSC encoding, 0 selects legacy encoding.
REQ-007 vld_in  in  1  channel match flags are valid this clock.
REQ-008 alct_clct_copad_match  in  NCH  per-channel ALCT+CLCT+GEM copad match.
REQ-009 alct_clct_gem_match  in  NCH  per-channel ALCT+CLCT+single GEM match.
REQ-010 alct_clct_match  in  NCH  per-channel ALCT+CLCT match.
REQ-011 clct_copad_match  in  NCH  per-channel CLCT+copad match.
REQ-012 alct_copad_match  in  NCH  per-channel ALCT+copad match.
REQ-013 gemcsc_bend_enable  in  NCH  per-channel GEM-CSC bend correction applied.
REQ-014 cnt_clear  in  1  synchronous clear of all occupancy counters.
REQ-015 cnt_sel  in  3  selects the quality counter driven on cnt_rd.
REQ-016 q_out  out  3*NCH  channel n quality on bits [3n+2:3n].
REQ-017 q_max  out  3  maximum quality over all channels in the same output word.
REQ-018 vld_out  out  1  q_out/q_max are valid this clock.
REQ-019 cnt_rd  out  CNT_W  value of counter cnt_sel (combinational mux of registered counters).

Function
REQ-020 Run-3 encoding per channel, first match wins: copad&&bend=7; copad&&!bend=6; gem&&bend=5; gem&&!bend=4; alct_clct=3; clct_copad=1; alct_copad=2; otherwise 0.
REQ-021 Legacy encoding (run3_en=0): Q=3 if alct_clct_match else 0; all GEM inputs and gemcsc_bend_enable are ignored.
REQ-022 run3_en is sampled with vld_in at the input stage; a change affects only words entering after the change.
REQ-023 Encoding is evaluated in the first stage; q_out, q_max, vld_out appear exactly PIPE_DEPTH clocks after the vld_in edge.
REQ-024 Pipeline shifts every clock, with no stall and no backpressure; back-to-back vld_in words produce back-to-back vld_out words.
REQ-025 When vld_out=0, q_out and q_max are 0.
REQ-026 q_max is the numerical maximum of the NCH channel qualities of the same word.
REQ-027 Counters: 8 counters, index 0..7 = quality value; counting is done at the output stage, on vld_out words only.
REQ-028 Per clock, counter k increments by the number of channels with q=k in the vld_out word (0..NCH); quality-0 channels increment counter 0.
REQ-029 Counters saturate at all-ones: if the increment would overflow, the counter is set to 2^CNT_W-1 and does not wrap.
REQ-030 cnt_clear=1 zeroes all counters on the next edge and takes precedence over a same-cycle increment, which is discarded.
REQ-031 cnt_clear does not affect pipeline contents or vld_out.

Reset
REQ-032 global_reset asserted clears all pipeline stages, vld_out, q_out, q_max and all counters to 0 immediately, without waiting for a clock edge.
REQ-033 Words in flight when global_reset asserts are discarded; the first vld_out after release corresponds to the first vld_in sampled after release.
REQ-034 After reset, cnt_rd = 0 for every cnt_sel.

Verification
REQ-035 NCH=2, PIPE_DEPTH=2, run3_en=1; ch0 copad=1 bend=1, ch1 gem=1 bend=0, vld_in=1 for one clock -> after 2 clocks q_out=6'b100_111, q_max=7, vld_out=1 for 1 clock; counter7=1, counter4=1.
REQ-036 Priority check: all five match flags set on ch0, bend=0 -> Q=6; only clct_copad and alct_copad set -> Q=1; only alct_copad set -> Q=2.
REQ-037 run3_en=0; ch0 copad=1 alct_clct=1 -> Q=3; ch0 copad=1 only -> Q=0; toggling run3_en mid-stream changes encoding only for the words sampled after the toggle.
REQ-038 CNT_W=8; 300 valid words, each with ch0 Q=3 -> counter3 saturates at 255 and stays there; cnt_clear with a coincident Q=3 word -> counter3=0 on the next clock.
REQ-039 Issue 3 back-to-back valid words, assert global_reset asynchronously mid-pipeline -> vld_out, q_out and counters go to 0 immediately; no stale vld_out after release.
REQ-040 NCH=4; all channels Q=5 in one word -> counter5 increments by 4 in a single clock.

Source files
------------

// File: rtl/lct_quality_pipe_if.sv
// Bus bundle for lct_quality_pipe: per-channel match flags in, qualities and counter readback out.
// The master drives the match flags and counter controls; the slave is the quality pipe.
interface lct_quality_pipe_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
);
  logic             run3_en;
  logic             vld_in;
  logic [NCH-1:0]   alct_clct_copad_match;
  logic [NCH-1:0]   alct_clct_gem_match;
  logic [NCH-1:0]   alct_clct_match;
  logic [NCH-1:0]   clct_copad_match;
  logic [NCH-1:0]   alct_copad_match;
  logic [NCH-1:0]   gemcsc_bend_enable;
  logic             cnt_clear;
  logic [2:0]       cnt_sel;
  logic [3*NCH-1:0] q_out;
  logic [2:0]       q_max;
  logic             vld_out;
  logic [CNT_W-1:0] cnt_rd;

  modport master (
    output run3_en, vld_in, alct_clct_copad_match, alct_clct_gem_match,
           alct_clct_match, clct_copad_match, alct_copad_match,
           gemcsc_bend_enable, cnt_clear, cnt_sel,
    input  q_out, q_max, vld_out, cnt_rd
  );

  modport slave (
    input  run3_en, vld_in, alct_clct_copad_match, alct_clct_gem_match,
           alct_clct_match, clct_copad_match, alct_copad_match,
           gemcsc_bend_enable, cnt_clear, cnt_sel,
    output q_out, q_max, vld_out, cnt_rd
  );
endinterface

// File: rtl/lct_quality_pipe.sv
// LCT quality encoder: per-channel priority encode, fixed-latency pipeline,
// and saturating per-quality occupancy counters tallied at the output stage.
module lct_quality_pipe #(
  parameter int NCH        = 2,
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_W      = 16
) (
  input logic            clock,
  input logic            global_reset,
  lct_quality_pipe_if.slave bus
);

  function automatic logic [2:0] encode_ch(
    input logic run3,
    input logic copad,
    input logic gem,
    input logic alct_clct,
    input logic clct_copad,
    input logic alct_copad,
    input logic bend
  );
    logic [2:0] q;
    q = 3'd0;
    if (!run3) begin
      q = alct_clct ? 3'd3 : 3'd0;
    end else if (copad) begin
      q = bend ? 3'd7 : 3'd6;
    end else if (gem) begin
      q = bend ? 3'd5 : 3'd4;
    end else if (alct_clct) begin
      q = 3'd3;
    end else if (clct_copad) begin
      q = 3'd1;
    end else if (alct_copad) begin
      q = 3'd2;
    end
    return q;
  endfunction

  logic [3*NCH-1:0]    enc;
  logic [3*NCH-1:0]    stage_q [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] stage_v;
  logic [3*NCH-1:0]    q_last;
  logic                v_last;
  logic [2:0]          q_max_c;
  logic [2:0]          inc [8];
  logic [CNT_W:0]      sum [8];
  logic [CNT_W-1:0]    cnt_nxt [8];
  logic [CNT_W-1:0]    cnt [8];

  // Invalid words enter as all-zero so q_out/q_max read 0 whenever vld_out is low.
  always_comb begin
    enc = '0;
    for (int n = 0; n < NCH; n++) begin
      if (bus.vld_in) begin
        enc[3*n +: 3] = encode_ch(bus.run3_en,
                                  bus.alct_clct_copad_match[n],
                                  bus.alct_clct_gem_match[n],
                                  bus.alct_clct_match[n],
                                  bus.clct_copad_match[n],
                                  bus.alct_copad_match[n],
                                  bus.gemcsc_bend_enable[n]);
      end
    end
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        stage_q[i] <= '0;
        stage_v[i] <= 1'b0;
      end
    end else begin
      stage_q[0] <= enc;
      stage_v[0] <= bus.vld_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
        stage_v[i] <= stage_v[i-1];
      end
    end
  end

  assign q_last = stage_q[PIPE_DEPTH-1];
  assign v_last = stage_v[PIPE_DEPTH-1];

  always_comb begin
    q_max_c = 3'd0;
    for (int n = 0; n < NCH; n++) begin
      if (q_last[3*n +: 3] > q_max_c) begin
        q_max_c = q_last[3*n +: 3];
      end
    end
  end

  // Sum is one bit wider than the counter; a carry out means saturate.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      inc[k] = 3'd0;
      for (int n = 0; n < NCH; n++) begin
        if (v_last && (q_last[3*n +: 3] == 3'(k))) begin
          inc[k] = inc[k] + 3'd1;
        end
      end
      sum[k]     = {1'b0, cnt[k]} + {{(CNT_W-2){1'b0}}, inc[k]};
      cnt_nxt[k] = sum[k][CNT_W] ? {CNT_W{1'b1}} : sum[k][CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      for (int k = 0; k < 8; k++) begin
        cnt[k] <= '0;
      end
    end else if (bus.cnt_clear) begin
      for (int k = 0; k < 8; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        cnt[k] <= cnt_nxt[k];
      end
    end
  end

  assign bus.q_out   = q_last;
  assign bus.q_max   = q_max_c;
  assign bus.vld_out = v_last;
  assign bus.cnt_rd  = cnt[bus.cnt_sel];

endmodule

// File: tb/tb_lct_quality_pipe.sv
// Directed bench for lct_quality_pipe: a 2-channel/depth-2/8-bit-counter instance
// and a 4-channel/depth-1 instance sharing clock and reset.
module tb_lct_quality_pipe;

  logic clock;
  logic global_reset;
  int   checks;
  int   failures;

  lct_quality_pipe_if #(.NCH(2), .CNT_W(8))  bus_a ();
  lct_quality_pipe_if #(.NCH(4), .CNT_W(16)) bus_b ();

  lct_quality_pipe #(.NCH(2), .PIPE_DEPTH(2), .CNT_W(8)) u_dut_a (
    .clock        (clock),
    .global_reset (global_reset),
    .bus          (bus_a)
  );

  lct_quality_pipe #(.NCH(4), .PIPE_DEPTH(1), .CNT_W(16)) u_dut_b (
    .clock        (clock),
    .global_reset (global_reset),
    .bus          (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    bus_a.vld_in = 1'b0;
    bus_a.run3_en = 1'b1;
    bus_a.alct_clct_copad_match = '0;
    bus_a.alct_clct_gem_match = '0;
    bus_a.alct_clct_match = '0;
    bus_a.clct_copad_match = '0;
    bus_a.alct_copad_match = '0;
    bus_a.gemcsc_bend_enable = '0;
  endtask

  task automatic idle_b();
    bus_b.vld_in = 1'b0;
    bus_b.run3_en = 1'b1;
    bus_b.alct_clct_copad_match = '0;
    bus_b.alct_clct_gem_match = '0;
    bus_b.alct_clct_match = '0;
    bus_b.clct_copad_match = '0;
    bus_b.alct_copad_match = '0;
    bus_b.gemcsc_bend_enable = '0;
  endtask

  task automatic set_a(input logic run3, input logic [1:0] cp, input logic [1:0] gm,
                       input logic [1:0] ac, input logic [1:0] cc, input logic [1:0] ap,
                       input logic [1:0] bd);
    bus_a.vld_in = 1'b1;
    bus_a.run3_en = run3;
    bus_a.alct_clct_copad_match = cp;
    bus_a.alct_clct_gem_match = gm;
    bus_a.alct_clct_match = ac;
    bus_a.clct_copad_match = cc;
    bus_a.alct_copad_match = ap;
    bus_a.gemcsc_bend_enable = bd;
  endtask

  task automatic set_b(input logic [3:0] cp, input logic [3:0] gm,
                       input logic [3:0] ac, input logic [3:0] bd);
    bus_b.vld_in = 1'b1;
    bus_b.run3_en = 1'b1;
    bus_b.alct_clct_copad_match = cp;
    bus_b.alct_clct_gem_match = gm;
    bus_b.alct_clct_match = ac;
    bus_b.clct_copad_match = '0;
    bus_b.alct_copad_match = '0;
    bus_b.gemcsc_bend_enable = bd;
  endtask

  task automatic chk_cnt_a(input int k, input int exp);
    bus_a.cnt_sel = 3'(k);
    @(negedge clock);
    chk($sformatf("a_cnt%0d", k), 32'(bus_a.cnt_rd), 32'(exp));
  endtask

  task automatic chk_cnt_b(input int k, input int exp);
    bus_b.cnt_sel = 3'(k);
    @(negedge clock);
    chk($sformatf("b_cnt%0d", k), 32'(bus_b.cnt_rd), 32'(exp));
  endtask

  // One isolated word through instance A: output checked exactly 2 clocks after entry.
  task automatic run_word_a(input string tag, input logic run3, input logic [1:0] cp,
                            input logic [1:0] gm, input logic [1:0] ac, input logic [1:0] cc,
                            input logic [1:0] ap, input logic [1:0] bd,
                            input logic [5:0] exp_q, input logic [2:0] exp_max);
    set_a(run3, cp, gm, ac, cc, ap, bd);
    tick();
    idle_a();
    chk({tag, "_vld_early"}, 32'(bus_a.vld_out), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(bus_a.vld_out), 32'd1);
    chk({tag, "_q"}, 32'(bus_a.q_out), 32'(exp_q));
    chk({tag, "_qmax"}, 32'(bus_a.q_max), 32'(exp_max));
    tick();
    chk({tag, "_vld_after"}, 32'(bus_a.vld_out), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    global_reset = 1'b1;
    idle_a();
    idle_b();
    bus_a.cnt_clear = 1'b0;
    bus_b.cnt_clear = 1'b0;
    bus_a.cnt_sel = 3'd0;
    bus_b.cnt_sel = 3'd0;
    #2;
    chk("rst_vld", 32'(bus_a.vld_out), 32'd0);
    chk("rst_q", 32'(bus_a.q_out), 32'd0);
    chk("rst_qmax", 32'(bus_a.q_max), 32'd0);
    #10;
    global_reset = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) chk_cnt_a(k, 0);
    tick();

    // Basic Run-3 word: ch0 copad+bend=7, ch1 gem no bend=4
    run_word_a("basic", 1'b1, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 6'h27, 3'd7);
    chk_cnt_a(7, 1);
    chk_cnt_a(4, 1);
    tick();
    // Priority checks on ch0
    run_word_a("prio6", 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 6'h06, 3'd6);
    run_word_a("prio1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 6'h01, 3'd1);
    run_word_a("prio2", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 6'h02, 3'd2);
    run_word_a("mix53", 1'b1, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 6'h2B, 3'd5);
    begin
      int exp_tally [8] = '{3, 1, 1, 1, 1, 1, 1, 1};
      for (int k = 0; k < 8; k++) chk_cnt_a(k, exp_tally[k]);
    end
    tick();

    // Legacy encoding
    run_word_a("leg3", 1'b0, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 6'h03, 3'd3);
    run_word_a("leg0", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'h00, 3'd0);

    // Back-to-back words toggling run3_en
    set_a(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    set_a(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    chk("tog_x_vld", 32'(bus_a.vld_out), 32'd1);
    chk("tog_x_q", 32'(bus_a.q_out), 32'h06);
    set_a(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    chk("tog_y_vld", 32'(bus_a.vld_out), 32'd1);
    chk("tog_y_q", 32'(bus_a.q_out), 32'h00);
    idle_a();
    tick();
    chk("tog_z_vld", 32'(bus_a.vld_out), 32'd1);
    chk("tog_z_q", 32'(bus_a.q_out), 32'h06);
    tick();
    chk("tog_end_vld", 32'(bus_a.vld_out), 32'd0);
    tick();
    chk_cnt_a(6, 3);
    chk_cnt_a(0, 10);
    chk_cnt_a(3, 2);

    // Plain clear
    bus_a.cnt_clear = 1'b1;
    tick();
    bus_a.cnt_clear = 1'b0;
    chk_cnt_a(6, 0);
    chk_cnt_a(0, 0);

    // Saturation with CNT_W=8
    tick();
    set_a(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    repeat (300) tick();
    idle_a();
    repeat (3) tick();
    chk_cnt_a(3, 255);
    chk_cnt_a(0, 255);
    chk_cnt_a(7, 0);
    tick();
    set_a(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    repeat (5) tick();
    idle_a();
    repeat (3) tick();
    chk_cnt_a(3, 255);

    // Clear coincident with a Q=3 word at the output; pipeline unaffected
    tick();
    set_a(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    tick();
    idle_a();
    bus_a.cnt_clear = 1'b1;
    tick();
    bus_a.cnt_clear = 1'b0;
    chk("clr_vld", 32'(bus_a.vld_out), 32'd1);
    chk("clr_q", 32'(bus_a.q_out), 32'h03);
    chk_cnt_a(3, 0);
    tick();
    chk_cnt_a(3, 1);
    chk_cnt_a(0, 1);

    // Async reset mid-pipeline
    tick();
    set_a(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    tick();
    tick();
    tick();
    idle_a();
    chk("prerst_vld", 32'(bus_a.vld_out), 32'd1);
    chk("prerst_q", 32'(bus_a.q_out), 32'h07);
    #2;
    global_reset = 1'b1;
    #1;
    chk("arst_vld", 32'(bus_a.vld_out), 32'd0);
    chk("arst_q", 32'(bus_a.q_out), 32'd0);
    chk("arst_qmax", 32'(bus_a.q_max), 32'd0);
    chk_cnt_a(7, 0);
    chk_cnt_a(3, 0);
    #2;
    global_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst_vld%0d", i), 32'(bus_a.vld_out), 32'd0);
    end
    run_word_a("postrst", 1'b1, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 6'h1C, 3'd4);

    // Four-channel instance
    chk_cnt_b(5, 0);
    tick();
    set_b(4'h0, 4'hF, 4'h0, 4'hF);
    tick();
    idle_b();
    chk("b_all5_vld", 32'(bus_b.vld_out), 32'd1);
    chk("b_all5_q", 32'(bus_b.q_out), 32'hB6D);
    chk("b_all5_qmax", 32'(bus_b.q_max), 32'd5);
    chk_cnt_b(5, 0);
    tick();
    chk("b_all5_vld_after", 32'(bus_b.vld_out), 32'd0);
    chk_cnt_b(5, 4);
    tick();
    set_b(4'b0011, 4'h0, 4'b1000, 4'b0001);
    tick();
    idle_b();
    chk("b_mix_q", 32'(bus_b.q_out), 32'h637);
    chk("b_mix_qmax", 32'(bus_b.q_max), 32'd7);
    tick();
    chk_cnt_b(7, 1);
    chk_cnt_b(6, 1);
    chk_cnt_b(3, 1);
    chk_cnt_b(0, 1);
    chk_cnt_b(5, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
